// File: rtl/sram_responder_pkg.sv
// -----------------------------------------------------------------------------
// sram_responder_pkg
// Shared bus widths, responder state encoding and the wait-counter helper used
// by the SRAM responder and its protocol checker.
// Ports: none (package).
// -----------------------------------------------------------------------------
package sram_responder_pkg;

   localparam int unsigned SRAM_ADDR_LEN = 17;
   localparam int unsigned SRAM_DATA_LEN = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRIVE = 2'd2
   } sram_state_e;

   // Wait-cycle counter step: increments and saturates at the read latency.
   function automatic logic [2:0] sat_inc(input logic [2:0] cur, input logic [2:0] lim);
      return (cur >= lim) ? lim : cur + 3'd1;
   endfunction

endpackage

// File: rtl/sram_responder_if.sv
// -----------------------------------------------------------------------------
// sram_responder_if
// Control/address side of the external asynchronous SRAM bus.
//   SRAM_ADDR  word address
//   SRAM_WE_N  write strobe, active low
//   SRAM_OE_N  output enable, active low
//   SRAM_CE_N  chip enable, active low
//   SRAM_UB_N  upper half-word lane enable, active low
//   SRAM_LB_N  lower half-word lane enable, active low
// The bidirectional data bus is kept as a plain inout port on the responder so
// tristate resolution happens on one ordinary net.
// Modports: master (SRAM controller side), slave (responder side).
// -----------------------------------------------------------------------------
interface sram_responder_if;
   import sram_responder_pkg::*;

   logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR;
   logic                     SRAM_WE_N;
   logic                     SRAM_OE_N;
   logic                     SRAM_CE_N;
   logic                     SRAM_UB_N;
   logic                     SRAM_LB_N;

   modport master (
      output SRAM_ADDR,
      output SRAM_WE_N,
      output SRAM_OE_N,
      output SRAM_CE_N,
      output SRAM_UB_N,
      output SRAM_LB_N
   );

   modport slave (
      input SRAM_ADDR,
      input SRAM_WE_N,
      input SRAM_OE_N,
      input SRAM_CE_N,
      input SRAM_UB_N,
      input SRAM_LB_N
   );

endinterface

// File: rtl/sram_protocol_checker.sv
// -----------------------------------------------------------------------------
// sram_protocol_checker
// Sticky detector for illegal SRAM strobe combinations. Only present when
// SRAM_RESP_PROTOCOL_CHECK_EN is defined; otherwise this file is empty.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   addr            SRAM word address
//   ce_n, we_n,
//   oe_n, ub_n,
//   lb_n            SRAM strobes (active low)
//   protocol_err    set on any violating edge, held until reset
// Violations: write with output enable, write with no lane enabled, and an
// address change while WE_N stays low across consecutive edges.
// -----------------------------------------------------------------------------
`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
module sram_protocol_checker
   import sram_responder_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [SRAM_ADDR_LEN-1:0] addr,
   input  logic                     ce_n,
   input  logic                     we_n,
   input  logic                     oe_n,
   input  logic                     ub_n,
   input  logic                     lb_n,
   output logic                     protocol_err
);

   logic [SRAM_ADDR_LEN-1:0] prev_addr_q, prev_addr_d;
   logic                     prev_we_q, prev_we_d;
   logic                     err_q, err_d;
   logic                     viol;

   always_comb begin
      prev_addr_d = addr;
      prev_we_d   = ~we_n;
      viol        = 1'b0;
      if (!ce_n && !we_n && !oe_n)      viol = 1'b1;
      if (!ce_n && !we_n && ub_n && lb_n) viol = 1'b1;
      if (!we_n && prev_we_q && (addr != prev_addr_q)) viol = 1'b1;
      err_d = err_q | viol;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_addr_q <= '0;
         prev_we_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         prev_addr_q <= prev_addr_d;
         prev_we_q   <= prev_we_d;
         err_q       <= err_d;
      end
   end

   assign protocol_err = err_q;

endmodule
`endif

// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
// Behavioural stand-in for the off-chip 32-bit asynchronous SRAM. Captures
// half-word-lane writes in one edge and returns read data on the shared data
// bus after READ_LATENCY stable request cycles.
// Parameters:
//   READ_LATENCY  edges from a stable read request to valid data (1..7)
//   MEM_DEPTH     words of storage, power of two; address wraps modulo depth
// Ports:
//   clk           clock
//   rst           asynchronous active-low reset
//   bus           SRAM address/strobes (sram_responder_if.slave)
//   SRAM_DQ       bidirectional data; driven only while a matured read holds
//   rd_valid      SRAM_DQ carries matured read data (registered)
//   protocol_err  sticky strobe-violation flag; built only when the macro
//                 SRAM_RESP_PROTOCOL_CHECK_EN is defined, else tied low
// Memory contents are deliberately not reset.
// -----------------------------------------------------------------------------
module sram_responder
   import sram_responder_pkg::*;
#(
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned MEM_DEPTH    = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   sram_responder_if.slave          bus,
   inout  wire  [SRAM_DATA_LEN-1:0] SRAM_DQ,
   output logic                     rd_valid,
   output logic                     protocol_err
);

   localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [2:0]  LAT   = 3'(READ_LATENCY);

   logic [SRAM_DATA_LEN-1:0] mem [MEM_DEPTH];

   logic [IDX_W-1:0]         idx;
   logic                     rd_req;
   logic                     wr_en;
   logic                     addr_chg;
   logic                     dq_oe;

   sram_state_e              state_q, state_d;
   logic [2:0]               cnt_q, cnt_d;
   logic [SRAM_ADDR_LEN-1:0] addr_q, addr_d;
   logic [SRAM_DATA_LEN-1:0] dout_q, dout_d;
   logic                     rd_valid_q, rd_valid_d;

   assign idx      = bus.SRAM_ADDR[IDX_W-1:0];
   assign rd_req   = ~bus.SRAM_CE_N & bus.SRAM_WE_N & ~bus.SRAM_OE_N;
   assign wr_en    = ~bus.SRAM_CE_N & ~bus.SRAM_WE_N;
   assign addr_chg = (bus.SRAM_ADDR != addr_q);

   // Entering WAIT always starts from zero, so the count only advances on
   // edges where the same address was already requested on the edge before;
   // this puts valid data exactly READ_LATENCY edges after the first edge.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = bus.SRAM_ADDR;
      dout_d     = dout_q;
      rd_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (rd_req) state_d = WAIT;
         end
         WAIT, DRIVE: begin
            if (!rd_req) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (addr_chg) begin
               state_d = WAIT;
               cnt_d   = '0;
            end else begin
               cnt_d = sat_inc(cnt_q, LAT);
               if (cnt_d == LAT) state_d = DRIVE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      if (state_d == DRIVE) begin
         rd_valid_d = 1'b1;
         dout_d     = mem[idx];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         dout_q     <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         dout_q     <= dout_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // Backing store: per-lane byte-pair writes, no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (!bus.SRAM_UB_N) mem[idx][31:16] <= SRAM_DQ[31:16];
         if (!bus.SRAM_LB_N) mem[idx][15:0]  <= SRAM_DQ[15:0];
      end
   end

   // The drive gate also compares against the latched address so an address
   // change releases the bus in the same cycle, before rd_valid clears.
   assign dq_oe    = rd_valid_q & rd_req & ~addr_chg;
   assign SRAM_DQ  = dq_oe ? dout_q : 'z;
   assign rd_valid = rd_valid_q;

`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
   sram_protocol_checker u_checker (
      .clk          (clk),
      .rst          (rst),
      .addr         (bus.SRAM_ADDR),
      .ce_n         (bus.SRAM_CE_N),
      .we_n         (bus.SRAM_WE_N),
      .oe_n         (bus.SRAM_OE_N),
      .ub_n         (bus.SRAM_UB_N),
      .lb_n         (bus.SRAM_LB_N),
      .protocol_err (protocol_err)
   );
`else
   assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
module tb_sram_responder;
   import sram_responder_pkg::*;

   localparam int unsigned RL    = 2;
   localparam int unsigned DEPTH = 1024;
   // Undriven bus floats to all ones through the pullups.
   localparam logic [31:0] ZVAL  = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst;
   wire  [31:0] SRAM_DQ;
   logic [31:0] tb_dq;
   logic        tb_dq_en;
   logic        rd_valid;
   logic        protocol_err;

   int checks = 0;
   int errors = 0;

   // Reference state
   logic [31:0] model_mem [DEPTH];
   bit          init_v    [DEPTH];
   int unsigned written[$];
   bit          viol_exp;
   bit          prev_we_low;
   logic [16:0] prev_addr;

   sram_responder_if bus ();

   always #5 clk = ~clk;

   assign SRAM_DQ = tb_dq_en ? tb_dq : 'z;
   for (genvar g = 0; g < 32; g++) begin : g_pull
      pullup (SRAM_DQ[g]);
   end

   sram_responder #(
      .READ_LATENCY (RL),
      .MEM_DEPTH    (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .SRAM_DQ      (SRAM_DQ),
      .rd_valid     (rd_valid),
      .protocol_err (protocol_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_err(input string tag);
`ifdef SRAM_RESP_PROTOCOL_CHECK_EN
      check(tag, 32'(protocol_err), 32'(viol_exp));
`else
      check(tag, 32'(protocol_err), 32'd0);
`endif
   endtask

   // One clock edge; the violation rules are evaluated on the inputs present
   // at that edge before moving past it.
   task automatic tick();
      if (rst) begin
         if (!bus.SRAM_CE_N && !bus.SRAM_WE_N && !bus.SRAM_OE_N) viol_exp = 1'b1;
         if (!bus.SRAM_CE_N && !bus.SRAM_WE_N && bus.SRAM_UB_N && bus.SRAM_LB_N) viol_exp = 1'b1;
         if (!bus.SRAM_WE_N && prev_we_low && (bus.SRAM_ADDR != prev_addr)) viol_exp = 1'b1;
         prev_we_low = !bus.SRAM_WE_N;
         prev_addr   = bus.SRAM_ADDR;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      bus.SRAM_CE_N = 1'b1;
      bus.SRAM_WE_N = 1'b1;
      bus.SRAM_OE_N = 1'b1;
      bus.SRAM_UB_N = 1'b1;
      bus.SRAM_LB_N = 1'b1;
      tb_dq_en      = 1'b0;
   endtask

   task automatic do_write(input logic [16:0] a, input logic [31:0] d,
                           input logic ub_n, input logic lb_n, input logic oe_n);
      int unsigned i;
      bus.SRAM_ADDR = a;
      bus.SRAM_CE_N = 1'b0;
      bus.SRAM_WE_N = 1'b0;
      bus.SRAM_OE_N = oe_n;
      bus.SRAM_UB_N = ub_n;
      bus.SRAM_LB_N = lb_n;
      tb_dq         = d;
      tb_dq_en      = 1'b1;
      tick();
      i = a % DEPTH;
      if (!ub_n) model_mem[i][31:16] = d[31:16];
      if (!lb_n) model_mem[i][15:0]  = d[15:0];
      if (!ub_n && !lb_n && !init_v[i]) begin
         init_v[i] = 1'b1;
         written.push_back(i);
      end
      bus_idle();
   endtask

   // Applies (or retargets) a read request and checks the bus stays released
   // for RL edges, then carries the modelled word.
   task automatic do_read(input logic [16:0] a, input logic ub_n, input logic lb_n,
                          input string tag);
      logic [31:0] expd;
      expd          = model_mem[a % DEPTH];
      bus.SRAM_ADDR = a;
      bus.SRAM_CE_N = 1'b0;
      bus.SRAM_WE_N = 1'b1;
      bus.SRAM_OE_N = 1'b0;
      bus.SRAM_UB_N = ub_n;
      bus.SRAM_LB_N = lb_n;
      tb_dq_en      = 1'b0;
      #1;
      check({tag, ".dq_z_req"}, SRAM_DQ, ZVAL);
      for (int k = 1; k <= int'(RL); k++) begin
         tick();
         check($sformatf("%s.valid_lo_e%0d", tag, k), 32'(rd_valid), 32'd0);
         check($sformatf("%s.dq_z_e%0d", tag, k), SRAM_DQ, ZVAL);
      end
      tick();
      check({tag, ".valid_hi"}, 32'(rd_valid), 32'd1);
      check({tag, ".data"}, SRAM_DQ, expd);
   endtask

   task automatic drop_read(input string tag);
      bus_idle();
      #1;
      check({tag, ".dq_release"}, SRAM_DQ, ZVAL);
      tick();
      check({tag, ".valid_clr"}, 32'(rd_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] d;
      logic [16:0] a;
      int unsigned op;
      int unsigned lanes;
      int unsigned i;

      rst         = 1'b1;
      tb_dq       = '0;
      tb_dq_en    = 1'b0;
      viol_exp    = 1'b0;
      prev_we_low = 1'b0;
      prev_addr   = '0;
      for (int n = 0; n < int'(DEPTH); n++) init_v[n] = 1'b0;
      bus.SRAM_ADDR = '0;
      bus_idle();
      #2 rst = 1'b0;
      #1;
      check("reset.rd_valid", 32'(rd_valid), 32'd0);
      check("reset.dq_z", SRAM_DQ, ZVAL);
      check("reset.protocol_err", 32'(protocol_err), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Basic write/read with latency
      do_write(17'h00010, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
      do_read(17'h00010, 1'b0, 1'b0, "basic");
      check("basic.const", SRAM_DQ, 32'hDEADBEEF);
      tick();
      check("basic.hold_valid", 32'(rd_valid), 32'd1);
      check("basic.hold_data", SRAM_DQ, 32'hDEADBEEF);
      drop_read("basic");
      check_err("basic.perr");

      // Upper-lane-only overwrite
      do_write(17'h00020, 32'h11112222, 1'b0, 1'b0, 1'b1);
      do_write(17'h00020, 32'hAAAA5555, 1'b0, 1'b1, 1'b1);
      do_read(17'h00020, 1'b1, 1'b1, "lane");
      check("lane.const", SRAM_DQ, 32'hAAAA2222);
      drop_read("lane");

      // Address change one cycle into a read
      do_write(17'h00005, 32'h05050505, 1'b0, 1'b0, 1'b1);
      do_write(17'h00006, 32'h06060606, 1'b0, 1'b0, 1'b1);
      bus.SRAM_ADDR = 17'h00005;
      bus.SRAM_CE_N = 1'b0;
      bus.SRAM_OE_N = 1'b0;
      tick();
      check("achg.valid_lo", 32'(rd_valid), 32'd0);
      do_read(17'h00006, 1'b0, 1'b0, "achg");
      check("achg.const", SRAM_DQ, 32'h06060606);
      drop_read("achg");

      // Address wrap
      do_write(17'h00400, 32'hCAFE0001, 1'b0, 1'b0, 1'b1);
      do_read(17'h00000, 1'b0, 1'b0, "wrap");
      check("wrap.const", SRAM_DQ, 32'hCAFE0001);
      drop_read("wrap");

      // Write aborts a driven read; adjacent read sees new data
      do_read(17'h00010, 1'b0, 1'b0, "abort");
      do_write(17'h00010, 32'h0BADF00D, 1'b0, 1'b0, 1'b1);
      check("abort.valid_clr", 32'(rd_valid), 32'd0);
      do_read(17'h00010, 1'b0, 1'b0, "raw");
      check("raw.const", SRAM_DQ, 32'h0BADF00D);
      drop_read("raw");
      check_err("directed.perr");

      // Randomized traffic against the model
      for (int it = 0; it < 24; it++) begin
         op = $urandom_range(0, 2);
         if (op < 2 || written.size() == 0) begin
            i = $urandom_range(0, 31);
            a = 17'((($urandom_range(0, 127)) << 10) | i);
            d = $urandom;
            if (d == ZVAL) d = 32'h0;
            lanes = init_v[i] ? $urandom_range(0, 3) : 0;
            do_write(a, d, lanes[1], lanes[0], 1'b1);
         end else begin
            i = written[$urandom_range(0, written.size() - 1)];
            a = 17'((($urandom_range(0, 127)) << 10) | i);
            lanes = $urandom_range(0, 3);
            do_read(a, lanes[1], lanes[0], $sformatf("rnd%0d", it));
            drop_read($sformatf("rnd%0d", it));
         end
         check_err($sformatf("rnd%0d.perr", it));
      end

      // Reset during DRIVE
      do_read(17'h00020, 1'b0, 1'b0, "prerst");
      rst = 1'b0;
      #1;
      check("rst.valid_clr", 32'(rd_valid), 32'd0);
      check("rst.dq_z", SRAM_DQ, ZVAL);
      check("rst.perr_clr", 32'(protocol_err), 32'd0);
      viol_exp    = 1'b0;
      prev_we_low = 1'b0;
      bus_idle();
      tick();
      tick();
      rst = 1'b1;
      do_read(17'h00020, 1'b0, 1'b0, "postrst");
      check("postrst.const", SRAM_DQ, 32'hAAAA2222);
      drop_read("postrst");
      check_err("postrst.perr");

      // Write with output enable asserted
      do_write(17'h00030, 32'h12345678, 1'b0, 1'b0, 1'b0);
      check_err("weoe.perr_set");
      tick();
      tick();
      check_err("weoe.perr_sticky");
      do_read(17'h00030, 1'b0, 1'b0, "weoe");
      drop_read("weoe");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
